sbr_stack: RTL and testbench

SBR_STACK -- requirements
Module: sbr_stack

---
 rtl/sbr_stack.sv | 114 +++++++++++
 tb/tb_sbr_stack.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/sbr_stack.sv
// Purpose : microcode subroutine return-address stack (16-entry circular LIFO).
// Latency : sbrRet is registered; a ret cycle sees the pre-pop top, new top one cycle later.
// Backpressure: none; push/pop act every cycle, and full/empty wrap instead of stalling.
//
// Ports:
//   clk, rstN        - clock (rising edge) and asynchronous active-low reset
//   call, ret        - CRAM CALL bit and decoded DISP/RETURN of the current microword
//   force1777        - page-fail trap; forces a push and suppresses any same-cycle ret
//   CRADR[0:10]      - current microword address, the value pushed
//   clrErr           - clears the sticky ovf/unf flags
//   sbrRet[0:10]     - registered top-of-stack return address
//   stackAdr[0:3]    - stack pointer (next free slot), for diagnostic readback
//   depth[4:0]       - valid entry count, 0..16 (saturating)
//   ovf, unf         - sticky overflow / underflow flags
//
// Build option: define SBR_STACK_CHECK_EN to enable the ovf/unf error flags;
// without it both flags are tied low and clrErr is ignored.
module sbr_stack #(
  parameter int DEPTH = 16,
  parameter int AW    = 11
) (
  input  logic          clk,
  input  logic          rstN,
  input  logic          call,
  input  logic          ret,
  input  logic          force1777,
  input  logic [0:AW-1] CRADR,
  input  logic          clrErr,
  output logic [0:AW-1] sbrRet,
  output logic [0:3]    stackAdr,
  output logic [4:0]    depth,
  output logic          ovf,
  output logic          unf
);

  localparam logic [4:0] FULL = 5'(DEPTH);

  logic [0:AW-1] entry [DEPTH];

  logic       push;
  logic       pop;
  logic [0:3] sp_m1;
  logic [0:3] sp_m2;

  // A trap always pushes; a return in the same cycle is discarded.
  assign push  = call | force1777;
  assign pop   = ret & ~force1777;
  // Pointer arithmetic wraps naturally in 4 bits.
  assign sp_m1 = stackAdr - 4'd1;
  assign sp_m2 = stackAdr - 4'd2;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      stackAdr <= '0;
      depth    <= '0;
      sbrRet   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        entry[i] <= '0;
      end
    end else begin
      case ({push, pop})
        2'b10: begin
          // Writing at a full stack silently overwrites the oldest slot.
          entry[stackAdr] <= CRADR;
          stackAdr        <= stackAdr + 4'd1;
          sbrRet          <= CRADR;
          if (depth != FULL) depth <= depth + 5'd1;
        end
        2'b01: begin
          // The entry below the one being popped becomes the new top; at
          // depth 0 this is a stale wrapped entry, returned as-is.
          stackAdr <= sp_m1;
          sbrRet   <= entry[sp_m2];
          if (depth != 5'd0) depth <= depth - 5'd1;
        end
        2'b11: begin
          // Call and return together replace the top in place.
          entry[sp_m1] <= CRADR;
          sbrRet       <= CRADR;
        end
        default: begin
        end
      endcase
    end
  end

`ifdef SBR_STACK_CHECK_EN
  logic ovf_set;
  logic unf_set;

  assign ovf_set = push & ~pop & (depth == FULL);
  assign unf_set = pop & ~push & (depth == 5'd0);

  // A set event in the same cycle as clrErr wins.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      ovf <= 1'b0;
      unf <= 1'b0;
    end else begin
      if (ovf_set)     ovf <= 1'b1;
      else if (clrErr) ovf <= 1'b0;
      if (unf_set)     unf <= 1'b1;
      else if (clrErr) unf <= 1'b0;
    end
  end
`else
  logic unused_clr_err;

  assign unused_clr_err = clrErr;
  assign ovf            = 1'b0;
  assign unf            = 1'b0;
`endif

endmodule

// File: tb/tb_sbr_stack.sv
// Purpose : self-checking bench for sbr_stack (push/pop, nesting, combined, trap, wrap, async reset).
// Latency : sbrRet expectations are queued when stimulus is driven and popped when the DUT is sampled.
// Backpressure: none; every cycle is driven explicitly by the tasks below.
module tb_sbr_stack;

  logic        clk = 1'b0;
  logic        rstN;
  logic        call;
  logic        ret;
  logic        force1777;
  logic [0:10] CRADR;
  logic        clrErr;
  logic [0:10] sbrRet;
  logic [0:3]  stackAdr;
  logic [4:0]  depth;
  logic        ovf;
  logic        unf;

  int n_checks = 0;
  int n_pass   = 0;

  logic [0:10] exp_q[$];
  logic [0:10] exp_v;

`ifdef SBR_STACK_CHECK_EN
  localparam logic CHK = 1'b1;
`else
  localparam logic CHK = 1'b0;
`endif

  sbr_stack #(.DEPTH(16), .AW(11)) dut (
    .clk      (clk),
    .rstN     (rstN),
    .call     (call),
    .ret      (ret),
    .force1777(force1777),
    .CRADR    (CRADR),
    .clrErr   (clrErr),
    .sbrRet   (sbrRet),
    .stackAdr (stackAdr),
    .depth    (depth),
    .ovf      (ovf),
    .unf      (unf)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Drive one cycle of inputs starting just after a rising edge; return 1ns after the next edge.
  task automatic cyc(input logic c, input logic r, input logic f, input logic [0:10] a);
    call      = c;
    ret       = r;
    force1777 = f;
    CRADR     = a;
    @(posedge clk);
    #1;
    call      = 1'b0;
    ret       = 1'b0;
    force1777 = 1'b0;
  endtask

  task automatic do_reset();
    rstN = 1'b0;
    #2;
    rstN = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstN = 1'b0; call = 1'b0; ret = 1'b0; force1777 = 1'b0; clrErr = 1'b0; CRADR = '0;
    #2;
    n_checks++; if (sbrRet !== 11'o0) $display("FAIL reset.sbrRet got %o want 0", sbrRet); else n_pass++;
    n_checks++; if (stackAdr !== 4'd0) $display("FAIL reset.stackAdr got %0d want 0", stackAdr); else n_pass++;
    n_checks++; if (depth !== 5'd0) $display("FAIL reset.depth got %0d want 0", depth); else n_pass++;
    n_checks++; if ({ovf, unf} !== 2'b00) $display("FAIL reset.flags got %b want 00", {ovf, unf}); else n_pass++;
    @(negedge clk);
    rstN = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_push_pop();
    exp_q.push_back(11'o0123);
    cyc(1'b1, 1'b0, 1'b0, 11'o0123);
    exp_v = exp_q.pop_front();
    n_checks++; if (sbrRet !== exp_v) $display("FAIL push_pop.sbrRet got %o want %o", sbrRet, exp_v); else n_pass++;
    n_checks++; if (stackAdr !== 4'd1) $display("FAIL push_pop.stackAdr got %0d want 1", stackAdr); else n_pass++;
    n_checks++; if (depth !== 5'd1) $display("FAIL push_pop.depth got %0d want 1", depth); else n_pass++;
    cyc(1'b0, 1'b1, 1'b0, 11'o0);
    n_checks++; if (stackAdr !== 4'd0) $display("FAIL push_pop.pop_stackAdr got %0d want 0", stackAdr); else n_pass++;
    n_checks++; if (depth !== 5'd0) $display("FAIL push_pop.pop_depth got %0d want 0", depth); else n_pass++;
  endtask

  task automatic test_nesting();
    cyc(1'b1, 1'b0, 1'b0, 11'o0100);
    cyc(1'b1, 1'b0, 1'b0, 11'o0200);
    cyc(1'b1, 1'b0, 1'b0, 11'o0300);
    exp_q.push_back(11'o0300);
    exp_q.push_back(11'o0200);
    exp_q.push_back(11'o0100);
    for (int k = 0; k < 3; k++) begin
      ret = 1'b1;
      #1;
      exp_v = exp_q.pop_front();
      n_checks++; if (sbrRet !== exp_v) $display("FAIL nesting.ret%0d got %o want %o", k, sbrRet, exp_v); else n_pass++;
      @(posedge clk);
      #1;
      ret = 1'b0;
    end
    n_checks++; if (depth !== 5'd0) $display("FAIL nesting.depth got %0d want 0", depth); else n_pass++;
  endtask

  task automatic test_combined();
    cyc(1'b1, 1'b0, 1'b0, 11'o0100);
    cyc(1'b1, 1'b0, 1'b0, 11'o0200);
    exp_q.push_back(11'o0555);
    cyc(1'b1, 1'b1, 1'b0, 11'o0555);
    exp_v = exp_q.pop_front();
    n_checks++; if (sbrRet !== exp_v) $display("FAIL combined.sbrRet got %o want %o", sbrRet, exp_v); else n_pass++;
    n_checks++; if (stackAdr !== 4'd2) $display("FAIL combined.stackAdr got %0d want 2", stackAdr); else n_pass++;
    n_checks++; if (depth !== 5'd2) $display("FAIL combined.depth got %0d want 2", depth); else n_pass++;
    // The entry below the replaced top is untouched.
    exp_q.push_back(11'o0100);
    cyc(1'b0, 1'b1, 1'b0, 11'o0);
    exp_v = exp_q.pop_front();
    n_checks++; if (sbrRet !== exp_v) $display("FAIL combined.after_pop got %o want %o", sbrRet, exp_v); else n_pass++;
    cyc(1'b0, 1'b1, 1'b0, 11'o0);
  endtask

  task automatic test_trap();
    exp_q.push_back(11'o0042);
    cyc(1'b0, 1'b1, 1'b1, 11'o0042);
    exp_v = exp_q.pop_front();
    n_checks++; if (sbrRet !== exp_v) $display("FAIL trap.sbrRet got %o want %o", sbrRet, exp_v); else n_pass++;
    n_checks++; if (depth !== 5'd1) $display("FAIL trap.depth got %0d want 1", depth); else n_pass++;
    n_checks++; if (stackAdr !== 4'd1) $display("FAIL trap.stackAdr got %0d want 1", stackAdr); else n_pass++;
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 1; i <= 16; i++) cyc(1'b1, 1'b0, 1'b0, 11'(i));
    n_checks++; if (depth !== 5'd16) $display("FAIL ovf.full_depth got %0d want 16", depth); else n_pass++;
    n_checks++; if (ovf !== 1'b0) $display("FAIL ovf.not_yet got %b want 0", ovf); else n_pass++;
    exp_q.push_back(11'o0021);
    cyc(1'b1, 1'b0, 1'b0, 11'o0021);
    exp_v = exp_q.pop_front();
    n_checks++; if (sbrRet !== exp_v) $display("FAIL ovf.sbrRet got %o want %o", sbrRet, exp_v); else n_pass++;
    n_checks++; if (depth !== 5'd16) $display("FAIL ovf.depth got %0d want 16", depth); else n_pass++;
    n_checks++; if (stackAdr !== 4'd1) $display("FAIL ovf.stackAdr got %0d want 1", stackAdr); else n_pass++;
    n_checks++; if (ovf !== CHK) $display("FAIL ovf.flag got %b want %b", ovf, CHK); else n_pass++;
    n_checks++; if (dut.entry[0] !== 11'o0021) $display("FAIL ovf.entry0 got %o want 0021", dut.entry[0]); else n_pass++;
  endtask

  // Continues from the full, wrapped stack left by test_overflow.
  task automatic test_underflow();
    for (int k = 0; k < 16; k++) exp_q.push_back(11'((k == 0) ? 17 : 17 - k));
    for (int k = 0; k < 16; k++) begin
      ret = 1'b1;
      #1;
      exp_v = exp_q.pop_front();
      n_checks++; if (sbrRet !== exp_v) $display("FAIL unf.drain%0d got %o want %o", k, sbrRet, exp_v); else n_pass++;
      @(posedge clk);
      #1;
      ret = 1'b0;
    end
    n_checks++; if (depth !== 5'd0) $display("FAIL unf.empty_depth got %0d want 0", depth); else n_pass++;
    n_checks++; if (unf !== 1'b0) $display("FAIL unf.not_yet got %b want 0", unf); else n_pass++;
    // Pop at depth 0 still retreats and returns the stale wrapped entry.
    exp_q.push_back(11'o0020);
    cyc(1'b0, 1'b1, 1'b0, 11'o0);
    exp_v = exp_q.pop_front();
    n_checks++; if (sbrRet !== exp_v) $display("FAIL unf.stale got %o want %o", sbrRet, exp_v); else n_pass++;
    n_checks++; if (stackAdr !== 4'd0) $display("FAIL unf.stackAdr got %0d want 0", stackAdr); else n_pass++;
    n_checks++; if (depth !== 5'd0) $display("FAIL unf.depth got %0d want 0", depth); else n_pass++;
    n_checks++; if (unf !== CHK) $display("FAIL unf.flag got %b want %b", unf, CHK); else n_pass++;
    // clrErr with a same-cycle underflow: unf stays set, ovf clears.
    clrErr = 1'b1;
    cyc(1'b0, 1'b1, 1'b0, 11'o0);
    clrErr = 1'b0;
    n_checks++; if (unf !== CHK) $display("FAIL clr.set_wins got %b want %b", unf, CHK); else n_pass++;
    n_checks++; if (ovf !== 1'b0) $display("FAIL clr.ovf got %b want 0", ovf); else n_pass++;
    n_checks++; if (stackAdr !== 4'd15) $display("FAIL clr.stackAdr got %0d want 15", stackAdr); else n_pass++;
    clrErr = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 11'o0);
    clrErr = 1'b0;
    n_checks++; if (unf !== 1'b0) $display("FAIL clr.unf got %b want 0", unf); else n_pass++;
  endtask

  task automatic test_async_reset();
    cyc(1'b1, 1'b0, 1'b0, 11'o0011);
    cyc(1'b1, 1'b0, 1'b0, 11'o0022);
    call  = 1'b1;
    CRADR = 11'o0777;
    #2;
    rstN = 1'b0;
    #1;
    n_checks++; if (sbrRet !== 11'o0) $display("FAIL arst.sbrRet got %o want 0", sbrRet); else n_pass++;
    n_checks++; if (stackAdr !== 4'd0) $display("FAIL arst.stackAdr got %0d want 0", stackAdr); else n_pass++;
    n_checks++; if (depth !== 5'd0) $display("FAIL arst.depth got %0d want 0", depth); else n_pass++;
    n_checks++; if (dut.entry[1] !== 11'o0) $display("FAIL arst.entry1 got %o want 0", dut.entry[1]); else n_pass++;
    @(posedge clk);
    #1;
    n_checks++; if (stackAdr !== 4'd0) $display("FAIL arst.held got %0d want 0", stackAdr); else n_pass++;
    @(negedge clk);
    rstN  = 1'b1;
    CRADR = 11'o0123;
    exp_q.push_back(11'o0123);
    @(posedge clk);
    #1;
    call = 1'b0;
    exp_v = exp_q.pop_front();
    n_checks++; if (sbrRet !== exp_v) $display("FAIL arst.resume_sbrRet got %o want %o", sbrRet, exp_v); else n_pass++;
    n_checks++; if (dut.entry[0] !== 11'o0123) $display("FAIL arst.entry0 got %o want 0123", dut.entry[0]); else n_pass++;
    n_checks++; if (stackAdr !== 4'd1) $display("FAIL arst.resume_stackAdr got %0d want 1", stackAdr); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_push_pop();
    test_nesting();
    test_combined();
    test_trap();
    test_overflow();
    test_underflow();
    test_async_reset();
    n_checks++; if (exp_q.size() != 0) $display("FAIL scoreboard.leftover got %0d want 0", exp_q.size()); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
